ctrl_pipe: RTL and testbench

Pipelined control unit for the 5-stage MIPS core. Decodes the ID-stage instruction into the ALU/memory/write-back control bundle and carries it through ID/EX, EX/MEM and MEM/WB registers. Adds load-use hazard detection, bubble insertion, branch flush, and a configurable-latency mult/div busy tracker. It replaces the purely combinational decoder.

---
 rtl/ctrl_pipe_pkg.sv | 72 +++++++
 rtl/ctrl_pipe_decode.sv | 150 +++++++++++++++
 rtl/ctrl_pipe.sv | 107 ++++++++++
 tb/tb_ctrl_pipe.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared encodings for the pipelined MIPS control unit: opcodes, functs,
// ALU/extension/select codes and the per-stage control bundles.
package ctrl_pipe_pkg;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E, OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20, OP_LH    = 6'h21, OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24, OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28, OP_SH    = 6'h29, OP_SW    = 6'h2B;

  // R-type functs
  localparam logic [5:0] FUNCT_SLL  = 6'h00, FUNCT_SRL  = 6'h02, FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04, FUNCT_SRLV = 6'h06, FUNCT_SRAV = 6'h07;
  localparam logic [5:0] FUNCT_JR   = 6'h08, FUNCT_JALR = 6'h09;
  localparam logic [5:0] FUNCT_MFHI = 6'h10, FUNCT_MTHI = 6'h11;
  localparam logic [5:0] FUNCT_MFLO = 6'h12, FUNCT_MTLO = 6'h13;
  localparam logic [5:0] FUNCT_MULT = 6'h18, FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV  = 6'h1A, FUNCT_DIVU  = 6'h1B;
  localparam logic [5:0] FUNCT_ADD  = 6'h20, FUNCT_ADDU = 6'h21, FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23, FUNCT_AND  = 6'h24, FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26, FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A, FUNCT_SLTU = 6'h2B;

  // ALU operations (0 = no operation, used by bubbles and illegal ops)
  localparam logic [4:0] ALUOP_NOP = 5'd0,  ALUOP_ADD = 5'd1,  ALUOP_SUB  = 5'd2;
  localparam logic [4:0] ALUOP_AND = 5'd3,  ALUOP_OR  = 5'd4,  ALUOP_XOR  = 5'd5;
  localparam logic [4:0] ALUOP_NOR = 5'd6,  ALUOP_SLT = 5'd7,  ALUOP_SLTU = 5'd8;
  localparam logic [4:0] ALUOP_SLL = 5'd9,  ALUOP_SRL = 5'd10, ALUOP_SRA  = 5'd11;
  localparam logic [4:0] ALUOP_LUI = 5'd12;

  localparam logic [1:0] EXTOP_ZERO = 2'd0, EXTOP_SIGN = 2'd1;
  localparam logic [1:0] JUMP_NONE  = 2'd0, JUMP_J = 2'd1, JUMP_JR = 2'd2;
  localparam logic [1:0] RDST_RT    = 2'd0, RDST_RD = 2'd1, RDST_RA = 2'd2;
  localparam logic [1:0] SRCA_RS    = 2'd0, SRCA_SHAMT = 2'd1, SRCA_PC8 = 2'd2;
  localparam logic [1:0] SRCB_RT    = 2'd0, SRCB_IMM = 2'd1;
  localparam logic [1:0] WB_ALU     = 2'd0, WB_MEM = 2'd1, WB_HILO = 2'd2;

  // ID/EX bundle; an all-zero value is a bubble
  typedef struct packed {
    logic [1:0] reg_dst;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [4:0] alu_op;
    logic [4:0] wreg;
    logic       md_start;
    logic [1:0] md_op;
    logic       illegal;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
  } idex_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [4:0] wreg;
    logic       reg_write;
    logic [1:0] mem_to_reg;
  } exmem_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [4:0] wreg;
  } memwb_t;

endpackage

// File: rtl/ctrl_pipe_decode.sv
// Combinational decoder: instruction -> control bundle, source-register use,
// jump class, immediate extension and HI/LO class.
module ctrl_decode
  import ctrl_pipe_pkg::*;
(
  input  logic [31:0] instr,
  output idex_t       bundle,
  output logic [1:0]  jump,
  output logic [1:0]  ext_op,
  output logic        uses_rs,
  output logic        uses_rt,
  output logic        is_hilo
);

  logic [5:0] op, funct;
  logic [4:0] rt, rd;
  logic       ok, imm_alu;
  logic       unused_bits;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign unused_bits = ^{instr[25:21], instr[10:6]};

  // Field decode; unknown encodings collapse to an all-zero bundle + illegal
  always_comb begin
    bundle  = '0;
    jump    = JUMP_NONE;
    ext_op  = EXTOP_ZERO;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    is_hilo = 1'b0;
    ok      = 1'b1;
    imm_alu = 1'b0;
    case (op)
      OP_RTYPE: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        bundle.reg_dst   = RDST_RD;
        bundle.reg_write = 1'b1;
        case (funct)
          FUNCT_ADD, FUNCT_ADDU: bundle.alu_op = ALUOP_ADD;
          FUNCT_SUB, FUNCT_SUBU: bundle.alu_op = ALUOP_SUB;
          FUNCT_AND:  bundle.alu_op = ALUOP_AND;
          FUNCT_OR:   bundle.alu_op = ALUOP_OR;
          FUNCT_XOR:  bundle.alu_op = ALUOP_XOR;
          FUNCT_NOR:  bundle.alu_op = ALUOP_NOR;
          FUNCT_SLT:  bundle.alu_op = ALUOP_SLT;
          FUNCT_SLTU: bundle.alu_op = ALUOP_SLTU;
          FUNCT_SLLV: bundle.alu_op = ALUOP_SLL;
          FUNCT_SRLV: bundle.alu_op = ALUOP_SRL;
          FUNCT_SRAV: bundle.alu_op = ALUOP_SRA;
          FUNCT_SLL, FUNCT_SRL, FUNCT_SRA: begin
            bundle.alu_op    = (funct == FUNCT_SLL) ? ALUOP_SLL :
                               (funct == FUNCT_SRL) ? ALUOP_SRL : ALUOP_SRA;
            bundle.alu_src_a = SRCA_SHAMT;
            uses_rs = 1'b0;
          end
          FUNCT_JR: begin
            jump = JUMP_JR;
            bundle.reg_write = 1'b0;
            uses_rt = 1'b0;
          end
          FUNCT_JALR: begin
            jump = JUMP_JR;
            bundle.alu_op    = ALUOP_ADD;
            bundle.alu_src_a = SRCA_PC8;
            uses_rt = 1'b0;
          end
          FUNCT_MFHI, FUNCT_MFLO: begin
            bundle.mem_to_reg = WB_HILO;
            uses_rs = 1'b0;
            uses_rt = 1'b0;
            is_hilo = 1'b1;
          end
          FUNCT_MTHI, FUNCT_MTLO: begin
            bundle.reg_write = 1'b0;
            uses_rt = 1'b0;
            is_hilo = 1'b1;
          end
          FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
            bundle.reg_write = 1'b0;
            bundle.md_start  = 1'b1;
            bundle.md_op     = funct[1:0];
            is_hilo = 1'b1;
          end
          default: ok = 1'b0;
        endcase
      end
      OP_J: jump = JUMP_J;
      OP_JAL: begin
        jump = JUMP_J;
        bundle.reg_dst   = RDST_RA;
        bundle.reg_write = 1'b1;
        bundle.alu_op    = ALUOP_ADD;
        bundle.alu_src_a = SRCA_PC8;
      end
      OP_BEQ, OP_BNE: begin
        bundle.alu_op = ALUOP_SUB;
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      OP_ADDI, OP_ADDIU: begin bundle.alu_op = ALUOP_ADD;  imm_alu = 1'b1; ext_op = EXTOP_SIGN; end
      OP_SLTI:           begin bundle.alu_op = ALUOP_SLT;  imm_alu = 1'b1; ext_op = EXTOP_SIGN; end
      OP_SLTIU:          begin bundle.alu_op = ALUOP_SLTU; imm_alu = 1'b1; ext_op = EXTOP_SIGN; end
      OP_ANDI:           begin bundle.alu_op = ALUOP_AND;  imm_alu = 1'b1; end
      OP_ORI:            begin bundle.alu_op = ALUOP_OR;   imm_alu = 1'b1; end
      OP_XORI:           begin bundle.alu_op = ALUOP_XOR;  imm_alu = 1'b1; end
      OP_LUI:            begin bundle.alu_op = ALUOP_LUI;  imm_alu = 1'b1; end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        bundle.alu_op     = ALUOP_ADD;
        bundle.alu_src_b  = SRCB_IMM;
        bundle.mem_read   = 1'b1;
        bundle.reg_write  = 1'b1;
        bundle.mem_to_reg = WB_MEM;
        ext_op  = EXTOP_SIGN;
        uses_rs = 1'b1;
      end
      OP_SB, OP_SH, OP_SW: begin
        bundle.alu_op    = ALUOP_ADD;
        bundle.alu_src_b = SRCB_IMM;
        bundle.mem_write = 1'b1;
        ext_op  = EXTOP_SIGN;
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    if (imm_alu) begin
      bundle.alu_src_b = SRCB_IMM;
      bundle.reg_write = 1'b1;
      uses_rs = (op != OP_LUI);
    end
    if (!ok) begin
      bundle  = '0;
      jump    = JUMP_NONE;
      ext_op  = EXTOP_ZERO;
      uses_rs = 1'b0;
      uses_rt = 1'b0;
      is_hilo = 1'b0;
      bundle.illegal = 1'b1;
    end
    // Destination is meaningful only for writers; everything else reports 0
    bundle.wreg = !bundle.reg_write       ? 5'd0 :
                  (bundle.reg_dst == RDST_RT) ? rt :
                  (bundle.reg_dst == RDST_RD) ? rd : 5'd31;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control: decode in ID, bundle carried through ID/EX, EX/MEM,
// MEM/WB, with load-use and mult/div hazard stalls and branch flush.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_instr,
  input  logic        flush_ex,
  input  logic        stall_ext,
  output logic        stall_id,
  output logic [1:0]  id_jump,
  output logic [1:0]  id_ext_op,
  output logic        id_illegal,
  output logic [1:0]  ex_reg_dst,
  output logic [1:0]  ex_alu_src_a,
  output logic [1:0]  ex_alu_src_b,
  output logic [4:0]  ex_alu_op,
  output logic [4:0]  ex_wreg,
  output logic        ex_md_start,
  output logic [1:0]  ex_md_op,
  output logic        ex_illegal,
  output logic        mem_mem_read,
  output logic        mem_mem_write,
  output logic [4:0]  mem_wreg,
  output logic        wb_reg_write,
  output logic [1:0]  wb_mem_to_reg,
  output logic [4:0]  wb_wreg
);

  idex_t      dec, ex_r;
  exmem_t     mem_r;
  memwb_t     wb_r;
  logic [5:0] md_cnt;
  logic       uses_rs, uses_rt, is_hilo;
  logic       load_use, md_busy, bubble;
  logic [4:0] rs, rt;

  ctrl_decode u_dec (
    .instr   (id_instr),
    .bundle  (dec),
    .jump    (id_jump),
    .ext_op  (id_ext_op),
    .uses_rs (uses_rs),
    .uses_rt (uses_rt),
    .is_hilo (is_hilo)
  );

  assign rs = id_instr[25:21];
  assign rt = id_instr[20:16];
  assign id_illegal = dec.illegal;

  assign load_use = ex_r.mem_read && (ex_r.wreg != 5'd0) &&
                    ((uses_rs && ex_r.wreg == rs) || (uses_rt && ex_r.wreg == rt));
  assign md_busy  = (md_cnt != 6'd0) && is_hilo;
  assign bubble   = flush_ex || load_use || md_busy;
  // A redirect replaces the ID instruction, so IF/ID must not hold for it
  assign stall_id = (load_use || md_busy || stall_ext) && !(flush_ex && !stall_ext);

  // Pipeline registers: freeze on memory stall, bubble ID/EX on hazard/flush
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r  <= '0;
      mem_r <= '0;
      wb_r  <= '0;
    end else if (!stall_ext) begin
      ex_r             <= bubble ? '0 : dec;
      mem_r.mem_read   <= ex_r.mem_read;
      mem_r.mem_write  <= ex_r.mem_write;
      mem_r.wreg       <= ex_r.wreg;
      mem_r.reg_write  <= ex_r.reg_write;
      mem_r.mem_to_reg <= ex_r.mem_to_reg;
      wb_r.reg_write   <= mem_r.reg_write;
      wb_r.mem_to_reg  <= mem_r.mem_to_reg;
      wb_r.wreg        <= mem_r.wreg;
    end
  end

  // Mult/div occupancy: the unit keeps counting through memory stalls
  always_ff @(posedge clk) begin
    if (rst)
      md_cnt <= 6'd0;
    else if (!stall_ext && !bubble && dec.md_start)
      md_cnt <= dec.md_op[1] ? 6'(DIV_LAT) : 6'(MUL_LAT);
    else if (md_cnt != 6'd0)
      md_cnt <= md_cnt - 6'd1;
  end

  assign ex_reg_dst    = ex_r.reg_dst;
  assign ex_alu_src_a  = ex_r.alu_src_a;
  assign ex_alu_src_b  = ex_r.alu_src_b;
  assign ex_alu_op     = ex_r.alu_op;
  assign ex_wreg       = ex_r.wreg;
  assign ex_md_start   = ex_r.md_start;
  assign ex_md_op      = ex_r.md_op;
  assign ex_illegal    = ex_r.illegal;
  assign mem_mem_read  = mem_r.mem_read;
  assign mem_mem_write = mem_r.mem_write;
  assign mem_wreg      = mem_r.wreg;
  assign wb_reg_write  = wb_r.reg_write;
  assign wb_mem_to_reg = wb_r.mem_to_reg;
  assign wb_wreg       = wb_r.wreg;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: decode vector table, hand-written hazard sequences,
// then random instruction streams against an instruction-level pipeline model.
module tb_ctrl_pipe;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic        clk = 1'b0, rst, flush_ex, stall_ext, stall_id, id_illegal;
  logic [31:0] id_instr;
  logic [1:0]  id_jump, id_ext_op, ex_reg_dst, ex_alu_src_a, ex_alu_src_b, ex_md_op, wb_mem_to_reg;
  logic [4:0]  ex_alu_op, ex_wreg, mem_wreg, wb_wreg;
  logic        ex_md_start, ex_illegal, mem_mem_read, mem_mem_write, wb_reg_write;

  ctrl_pipe #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .flush_ex(flush_ex), .stall_ext(stall_ext),
    .stall_id(stall_id), .id_jump(id_jump), .id_ext_op(id_ext_op), .id_illegal(id_illegal),
    .ex_reg_dst(ex_reg_dst), .ex_alu_src_a(ex_alu_src_a), .ex_alu_src_b(ex_alu_src_b),
    .ex_alu_op(ex_alu_op), .ex_wreg(ex_wreg), .ex_md_start(ex_md_start), .ex_md_op(ex_md_op),
    .ex_illegal(ex_illegal), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_wreg(mem_wreg), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_wreg(wb_wreg));

  always #5 clk = ~clk;

  logic [19:0] ex_vec;
  logic [6:0]  mem_vec;
  logic [7:0]  wb_vec;
  logic [5:0]  id_vec;
  assign ex_vec  = {ex_reg_dst, ex_alu_src_a, ex_alu_src_b, ex_alu_op, ex_wreg, ex_md_start, ex_md_op, ex_illegal};
  assign mem_vec = {mem_mem_read, mem_mem_write, mem_wreg};
  assign wb_vec  = {wb_reg_write, wb_mem_to_reg, wb_wreg};
  assign id_vec  = {stall_id, id_jump, id_ext_op, id_illegal};

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; id_instr = 32'h0; flush_ex = 1'b0; stall_ext = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // Instruction-level view of what the spec says each instruction does
  typedef struct packed {
    logic [1:0] jump, ext;
    logic       ill;
    logic [1:0] rdst, sa, sb;
    logic [4:0] alu, wreg;
    logic       md;
    logic [1:0] mdop;
    logic       mr, mw, rw;
    logic [1:0] m2r;
    logic       urs, urt, hilo;
  } rec_t;

  function automatic rec_t ref_dec(input logic [31:0] i);
    rec_t r;
    logic [5:0] op, f;
    op = i[31:26]; f = i[5:0];
    r = '0;
    if (op == 6'h00) begin
      r.urs = 1; r.urt = 1; r.rw = 1; r.rdst = 2'd1;
      case (f)
        6'h20, 6'h21: r.alu = 5'd1;
        6'h22, 6'h23: r.alu = 5'd2;
        6'h24: r.alu = 5'd3;  6'h25: r.alu = 5'd4;  6'h26: r.alu = 5'd5;
        6'h27: r.alu = 5'd6;  6'h2A: r.alu = 5'd7;  6'h2B: r.alu = 5'd8;
        6'h04: r.alu = 5'd9;  6'h06: r.alu = 5'd10; 6'h07: r.alu = 5'd11;
        6'h00: begin r.alu = 5'd9;  r.sa = 2'd1; r.urs = 0; end
        6'h02: begin r.alu = 5'd10; r.sa = 2'd1; r.urs = 0; end
        6'h03: begin r.alu = 5'd11; r.sa = 2'd1; r.urs = 0; end
        6'h08: begin r.jump = 2'd2; r.rw = 0; r.urt = 0; end
        6'h09: begin r.jump = 2'd2; r.alu = 5'd1; r.sa = 2'd2; r.urt = 0; end
        6'h10, 6'h12: begin r.m2r = 2'd2; r.urs = 0; r.urt = 0; r.hilo = 1; end
        6'h11, 6'h13: begin r.rw = 0; r.urt = 0; r.hilo = 1; end
        6'h18, 6'h19, 6'h1A, 6'h1B: begin r.rw = 0; r.md = 1; r.mdop = f[1:0]; r.hilo = 1; end
        default: r.ill = 1;
      endcase
    end else if (op == 6'h02) r.jump = 2'd1;
    else if (op == 6'h03) begin r.jump = 2'd1; r.rw = 1; r.rdst = 2'd2; r.alu = 5'd1; r.sa = 2'd2; end
    else if (op inside {6'h04, 6'h05}) begin r.alu = 5'd2; r.urs = 1; r.urt = 1; end
    else if (op inside {[6'h08:6'h0F]}) begin
      case (op[2:0])
        3'd0, 3'd1: r.alu = 5'd1;  3'd2: r.alu = 5'd7;  3'd3: r.alu = 5'd8;
        3'd4: r.alu = 5'd3;        3'd5: r.alu = 5'd4;  3'd6: r.alu = 5'd5;
        default: r.alu = 5'd12;
      endcase
      r.urs = (op != 6'h0F); r.rw = 1; r.sb = 2'd1; r.ext = (op <= 6'h0B) ? 2'd1 : 2'd0;
    end else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
      r.alu = 5'd1; r.sb = 2'd1; r.urs = 1; r.rw = 1; r.mr = 1; r.m2r = 2'd1; r.ext = 2'd1;
    end else if (op inside {6'h28, 6'h29, 6'h2B}) begin
      r.alu = 5'd1; r.sb = 2'd1; r.urs = 1; r.urt = 1; r.mw = 1; r.ext = 2'd1;
    end else r.ill = 1;
    if (r.ill) begin r = '0; r.ill = 1; end
    r.wreg = !r.rw ? 5'd0 : (r.rdst == 2'd0) ? i[20:16] : (r.rdst == 2'd1) ? i[15:11] : 5'd31;
    return r;
  endfunction

  function automatic logic [19:0] ex_of(input rec_t r);
    return {r.rdst, r.sa, r.sb, r.alu, r.wreg, r.md, r.mdop, r.ill};
  endfunction

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  jump, ext;
    logic        ill;
    logic [4:0]  alu, wreg;
  } vec_t;

  vec_t        tv [16];
  logic [31:0] pool [0:30];

  initial begin
    // Decode vectors: {instr, jump, ext, illegal, ex_alu_op, ex_wreg}
    tv[0]  = '{32'h00221821, 2'd0, 2'd0, 1'b0, 5'd1,  5'd3};   // addu $3,$1,$2
    tv[1]  = '{32'h00221823, 2'd0, 2'd0, 1'b0, 5'd2,  5'd3};   // subu $3,$1,$2
    tv[2]  = '{32'h00021080, 2'd0, 2'd0, 1'b0, 5'd9,  5'd2};   // sll $2,$2,2
    tv[3]  = '{32'h2022FFFF, 2'd0, 2'd1, 1'b0, 5'd1,  5'd2};   // addi $2,$1,-1
    tv[4]  = '{32'h342200FF, 2'd0, 2'd0, 1'b0, 5'd4,  5'd2};   // ori $2,$1,0xff
    tv[5]  = '{32'h3C051234, 2'd0, 2'd0, 1'b0, 5'd12, 5'd5};   // lui $5
    tv[6]  = '{32'hAC220004, 2'd0, 2'd1, 1'b0, 5'd1,  5'd0};   // sw $2,4($1)
    tv[7]  = '{32'h10220003, 2'd0, 2'd0, 1'b0, 5'd2,  5'd0};   // beq $1,$2
    tv[8]  = '{32'h08000010, 2'd1, 2'd0, 1'b0, 5'd0,  5'd0};   // j
    tv[9]  = '{32'h0C000010, 2'd1, 2'd0, 1'b0, 5'd1,  5'd31};  // jal
    tv[10] = '{32'h00200008, 2'd2, 2'd0, 1'b0, 5'd0,  5'd0};   // jr $1
    tv[11] = '{32'h0020F809, 2'd2, 2'd0, 1'b0, 5'd1,  5'd31};  // jalr $31,$1
    tv[12] = '{32'hFC000000, 2'd0, 2'd0, 1'b1, 5'd0,  5'd0};   // bad opcode
    tv[13] = '{32'h0000003F, 2'd0, 2'd0, 1'b1, 5'd0,  5'd0};   // bad funct
    tv[14] = '{32'h00002010, 2'd0, 2'd0, 1'b0, 5'd0,  5'd4};   // mfhi $4
    tv[15] = '{32'h8C220000, 2'd0, 2'd1, 1'b0, 5'd1,  5'd2};   // lw $2,0($1)
    pool = '{32'h00000021, 32'h00000023, 32'h00000025, 32'h0000002A, 32'h00000000,
             32'h00000007, 32'h00000008, 32'h00000009, 32'h00000010, 32'h00000012,
             32'h00000011, 32'h00000018, 32'h00000019, 32'h0000001A, 32'h0000001B,
             32'h00000013, 32'h0000003F, 32'h20000000, 32'h34000000, 32'h3C000000,
             32'h8C000000, 32'h8C000000, 32'h90000000, 32'hAC000000, 32'h10000000,
             32'h14000000, 32'h08000000, 32'h0C000000, 32'hFC000000, 32'h28000000,
             32'h2C000000};

    // Reset state
    do_reset();
    chk("reset_ex", ex_vec, 0);
    chk("reset_mem", mem_vec, 0);
    chk("reset_wb", wb_vec, 0);
    chk("reset_id_nop", id_vec, 0);

    // Decode table
    for (int i = 0; i < 16; i++) begin
      id_instr = tv[i].instr;
      #1;
      chk($sformatf("tv%0d_id", i), id_vec, {1'b0, tv[i].jump, tv[i].ext, tv[i].ill});
      step();
      chk($sformatf("tv%0d_ex", i), {ex_alu_op, ex_wreg, ex_illegal}, {tv[i].alu, tv[i].wreg, tv[i].ill});
    end

    // addu latency through WB
    do_reset();
    id_instr = 32'h00221821; step();
    chk("addu_ex", {ex_alu_op, ex_wreg}, {5'd1, 5'd3});
    id_instr = 32'h0; step(); step();
    chk("addu_wb", wb_vec, {1'b1, 2'd0, 5'd3});

    // Load-use: one bubble
    do_reset();
    id_instr = 32'h8C220000; step();
    id_instr = 32'h00411821; #1;
    chk("lu_stall", stall_id, 1);
    step();
    chk("lu_bubble", ex_vec, 0);
    chk("lu_release", stall_id, 0);
    step();
    chk("lu_addu_ex", {ex_alu_op, ex_wreg}, {5'd1, 5'd3});

    // MULT then MFLO: MUL_LAT stall cycles
    do_reset();
    id_instr = 32'h00220018; step();
    chk("mult_start", {ex_md_start, ex_md_op}, {1'b1, 2'd0});
    id_instr = 32'h00002012; #1;
    begin
      int n = 0;
      for (int k = 0; k < 20 && stall_id; k++) begin n++; step(); end
      chk("mult_stall_cycles", n, MUL_LAT);
    end
    chk("mult_pulse_end", ex_md_start, 0);
    step(); id_instr = 32'h0; step(); step();
    chk("mflo_wb", wb_vec, {1'b1, 2'd2, 5'd4});

    // Flush over load-use: bubble, no stall
    do_reset();
    id_instr = 32'h8C220000; step();
    id_instr = 32'h00411821; flush_ex = 1'b1; #1;
    chk("flush_lu_stall", stall_id, 0);
    step();
    chk("flush_lu_bubble", ex_vec, 0);
    chk("flush_lu_mem", mem_mem_read, 1);
    flush_ex = 1'b0;

    // Same with memory stall: everything frozen
    do_reset();
    id_instr = 32'h8C220000; step();
    id_instr = 32'h00411821; flush_ex = 1'b1; stall_ext = 1'b1; #1;
    chk("frz_stall", stall_id, 1);
    step(); step();
    chk("frz_ex", {ex_alu_op, ex_wreg}, {5'd1, 5'd2});
    chk("frz_mem", mem_vec, 0);
    stall_ext = 1'b0; step();
    chk("frz_rel_ex", ex_vec, 0);
    chk("frz_rel_mem", mem_mem_read, 1);
    flush_ex = 1'b0;

    // Illegal opcode travels as a non-writing bundle
    do_reset();
    id_instr = 32'hFC000000; #1;
    chk("ill_id", id_illegal, 1);
    step();
    chk("ill_ex", ex_illegal, 1);
    id_instr = 32'h0; step(); step();
    chk("ill_wb", wb_reg_write, 0);

    // Reset mid-divide clears the counter
    do_reset();
    id_instr = 32'h0022001A; step();
    id_instr = 32'h00002010; #1;
    chk("div_busy", stall_id, 1);
    id_instr = 32'h0; step(); step(); step();
    rst = 1'b1; step();
    chk("rst_ex", ex_vec, 0);
    chk("rst_mem", mem_vec, 0);
    chk("rst_wb", wb_vec, 0);
    rst = 1'b0; id_instr = 32'h00002010; #1;
    chk("rst_no_stall", stall_id, 0);

    // Random streams vs. instruction-level model
    do_reset();
    begin
      rec_t m_ex, m_mem, m_wb, d;
      int m_cnt;
      logic [31:0] cur;
      logic hold, lu, busy, bub;
      m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0; hold = 0; cur = 0;
      for (int c = 0; c < 800; c++) begin
        if (!hold)
          cur = pool[$urandom_range(0, 30)] | ($urandom_range(0, 3) << 21) |
                ($urandom_range(0, 3) << 16) | ($urandom_range(0, 3) << 11);
        if (!stall_ext) flush_ex = ($urandom_range(0, 7) == 0);
        stall_ext = ($urandom_range(0, 7) == 0);
        id_instr = cur;
        d = ref_dec(cur);
        lu = m_ex.mr && m_ex.wreg != 0 &&
             ((d.urs && m_ex.wreg == cur[25:21]) || (d.urt && m_ex.wreg == cur[20:16]));
        busy = (m_cnt > 0) && d.hilo;
        bub  = flush_ex || lu || busy;
        hold = stall_ext || (!flush_ex && (lu || busy));
        #1;
        chk("rnd_id", id_vec, {hold, d.jump, d.ext, d.ill});
        step();
        if (!stall_ext) begin m_wb = m_mem; m_mem = m_ex; m_ex = bub ? '0 : d; end
        if (!stall_ext && !bub && d.md) m_cnt = d.mdop[1] ? DIV_LAT : MUL_LAT;
        else if (m_cnt > 0) m_cnt--;
        chk("rnd_ex", ex_vec, ex_of(m_ex));
        chk("rnd_mem", mem_vec, {m_mem.mr, m_mem.mw, m_mem.wreg});
        chk("rnd_wb", wb_vec, {m_wb.rw, m_wb.m2r, m_wb.wreg});
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
